// File: rtl/trig_param_bank.sv
// -----------------------------------------------------------------------------
// trig_param_bank
//
// Purpose:
//   Bank of NCH trigger-loaded parameter registers that feed the model cores
//   (spindle, neuron-pool and muscle coefficients such as gamma_dyn, gain,
//   tau and BDAMP).
//
//   Each channel has two registers:
//     - shadow: loaded by the host through a trigger pulse.
//     - active: drives the model.
//   A channel holding an uncommitted shadow value is PENDING. On commit_tick,
//   every pending channel copies its shadow into its active register in the
//   same clock edge. The model therefore never sees a coefficient set that is
//   only partly updated within one simulation step.
//
// Parameters:
//   NCH      number of channels (2..32)
//   DW       parameter width (1..32). The captured word is
//            {wire_hi, wire_lo}[DW-1:0].
//   DEFAULTS packed NCH*DW reset/clear image. Channel i is at [i*DW +: DW].
//   SELW     width of rd_sel
//
// Ports:
//   clk            system clock (clk1 domain)
//   reset          asynchronous, active-low reset
//   trig[NCH]      one-cycle load pulses. Bit i loads channel i.
//   wire_lo/hi     host wires. Together they form the 32-bit capture word.
//   commit_tick    one-cycle pulse, once per simulation step
//   soft_clear     synchronous return of all state to DEFAULTS.
//                  It wins over trig and commit_tick in the same cycle.
//   rd_sel         readback channel select
//   rd_shadow      (optional) 1 = read back shadow[rd_sel] instead of active
//   params_out     active values. Channel i is at [i*DW +: DW].
//   pending        per-channel "shadow holds an uncommitted value" flag
//   update_strobe  one-cycle pulse after a commit that moved a channel
//   rd_data        registered readback of active[rd_sel].
//                  It returns 0 when rd_sel >= NCH.
//   overrun_cnt    saturating count of cycles in which a trigger overwrote
//                  an uncommitted shadow
//
// Build option:
//   TRIG_PARAM_BANK_SHADOW_RD_EN
//     When defined, this adds the rd_shadow input, which selects the shadow
//     registers as the readback source.
// -----------------------------------------------------------------------------
module trig_param_bank #(
  parameter int                  NCH      = 16,
  parameter int                  DW       = 32,
  parameter logic [NCH*DW-1:0]   DEFAULTS = '0,
  parameter int                  SELW     = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         trig,
  input  logic [15:0]            wire_lo,
  input  logic [15:0]            wire_hi,
  input  logic                   commit_tick,
  input  logic                   soft_clear,
  input  logic [SELW-1:0]        rd_sel,
`ifdef TRIG_PARAM_BANK_SHADOW_RD_EN
  input  logic                   rd_shadow,
`endif
  output logic [NCH*DW-1:0]      params_out,
  output logic [NCH-1:0]         pending,
  output logic                   update_strobe,
  output logic [DW-1:0]          rd_data,
  output logic [15:0]            overrun_cnt
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } ch_state_e;

  // Capture word shared by every channel triggered in the same cycle.
  logic [31:0]   word_full;
  logic [DW-1:0] cap_word;

  assign word_full = {wire_hi, wire_lo};
  assign cap_word  = word_full[DW-1:0];

  logic [DW-1:0] active_arr [NCH];
`ifdef TRIG_PARAM_BANK_SHADOW_RD_EN
  logic [DW-1:0] shadow_arr [NCH];
`endif

  // Per-channel flag: a trigger hit a channel that was already pending and is
  // not committing in this cycle.
  logic [NCH-1:0] ovr_hit;

  // ---------------------------------------------------------------------------
  // Per-channel IDLE/PENDING state machine with shadow and active registers
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    localparam logic [DW-1:0] CH_DEFAULT = DEFAULTS[gi*DW +: DW];

    ch_state_e     state_q, state_d;
    logic [DW-1:0] shadow_q, shadow_d;
    logic [DW-1:0] active_q, active_d;

    always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      active_d = active_q;
      if (soft_clear) begin
        state_d  = ST_IDLE;
        shadow_d = CH_DEFAULT;
        active_d = CH_DEFAULT;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (trig[gi]) begin
              shadow_d = cap_word;
              state_d  = ST_PENDING;
            end
          end
          ST_PENDING: begin
            // If a commit and a trigger arrive together:
            //   - active takes the OLD shadow value;
            //   - shadow takes the new word;
            //   - the channel stays pending and holds the new word for the
            //     next tick.
            if (commit_tick) begin
              active_d = shadow_q;
            end
            if (trig[gi]) begin
              shadow_d = cap_word;
            end
            if (commit_tick && !trig[gi]) begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q  <= ST_IDLE;
        shadow_q <= CH_DEFAULT;
        active_q <= CH_DEFAULT;
      end else begin
        state_q  <= state_d;
        shadow_q <= shadow_d;
        active_q <= active_d;
      end
    end

    assign pending[gi]              = (state_q == ST_PENDING);
    assign ovr_hit[gi]              = (state_q == ST_PENDING) && trig[gi] && !commit_tick;
    assign params_out[gi*DW +: DW]  = active_q;
    assign active_arr[gi]           = active_q;
`ifdef TRIG_PARAM_BANK_SHADOW_RD_EN
    assign shadow_arr[gi]           = shadow_q;
`endif
  end

  // ---------------------------------------------------------------------------
  // Readback range check.
  // The check is only built when rd_sel can encode channel numbers that do
  // not exist.
  // ---------------------------------------------------------------------------
  logic sel_ok;

  if ((1 << SELW) > NCH) begin : g_sel_chk
    assign sel_ok = (int'(rd_sel) < NCH);
  end else begin : g_sel_full
    assign sel_ok = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Bank-level registers: overrun counter, update strobe, readback
  // ---------------------------------------------------------------------------
  logic [15:0]   overrun_cnt_q, overrun_cnt_d;
  logic          update_strobe_q, update_strobe_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  always_comb begin
    overrun_cnt_d   = overrun_cnt_q;
    update_strobe_d = 1'b0;
    rd_data_d       = '0;
    if (soft_clear) begin
      overrun_cnt_d = '0;
    end else begin
      // At most one count per cycle, however many channels overran.
      if ((|ovr_hit) && (overrun_cnt_q != 16'hFFFF)) begin
        overrun_cnt_d = overrun_cnt_q + 16'd1;
      end
      update_strobe_d = commit_tick && (|pending);
      // Readback samples the registers as they stand in this cycle.
      if (sel_ok) begin
`ifdef TRIG_PARAM_BANK_SHADOW_RD_EN
        rd_data_d = rd_shadow ? shadow_arr[rd_sel] : active_arr[rd_sel];
`else
        rd_data_d = active_arr[rd_sel];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_cnt_q   <= '0;
      update_strobe_q <= 1'b0;
      rd_data_q       <= '0;
    end else begin
      overrun_cnt_q   <= overrun_cnt_d;
      update_strobe_q <= update_strobe_d;
      rd_data_q       <= rd_data_d;
    end
  end

  assign overrun_cnt   = overrun_cnt_q;
  assign update_strobe = update_strobe_q;
  assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_trig_param_bank.sv
// -----------------------------------------------------------------------------
// tb_trig_param_bank
//
// Directed testbench for trig_param_bank.
//   - NCH = 12, so that rd_sel can address a channel that does not exist.
//   - Channel 0 defaults to 42A0_0000. Channel i>0 defaults to D0D0_0000 + i.
// Inputs change 1 time unit after a rising clock edge. Outputs are sampled at
// that same point, which is also away from the edge.
// -----------------------------------------------------------------------------
module tb_trig_param_bank;

  localparam int NCH  = 12;
  localparam int DW   = 32;
  localparam int SELW = $clog2(NCH);
  localparam logic [NCH*DW-1:0] DEFS = {
    32'hD0D0_000B, 32'hD0D0_000A, 32'hD0D0_0009, 32'hD0D0_0008,
    32'hD0D0_0007, 32'hD0D0_0006, 32'hD0D0_0005, 32'hD0D0_0004,
    32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001, 32'h42A0_0000
  };

  logic                clk;
  logic                reset;
  logic [NCH-1:0]      trig;
  logic [15:0]         wire_lo;
  logic [15:0]         wire_hi;
  logic                commit_tick;
  logic                soft_clear;
  logic [SELW-1:0]     rd_sel;
`ifdef TRIG_PARAM_BANK_SHADOW_RD_EN
  logic                rd_shadow;
`endif
  logic [NCH*DW-1:0]   params_out;
  logic [NCH-1:0]      pending;
  logic                update_strobe;
  logic [DW-1:0]       rd_data;
  logic [15:0]         overrun_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  trig_param_bank #(
    .NCH      (NCH),
    .DW       (DW),
    .DEFAULTS (DEFS),
    .SELW     (SELW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .trig          (trig),
    .wire_lo       (wire_lo),
    .wire_hi       (wire_hi),
    .commit_tick   (commit_tick),
    .soft_clear    (soft_clear),
    .rd_sel        (rd_sel),
`ifdef TRIG_PARAM_BANK_SHADOW_RD_EN
    .rd_shadow     (rd_shadow),
`endif
    .params_out    (params_out),
    .pending       (pending),
    .update_strobe (update_strobe),
    .rd_data       (rd_data),
    .overrun_cnt   (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected default for channel i, written independently of DEFS.
  function automatic logic [31:0] def_of(input int i);
    if (i == 0) return 32'h42A0_0000;
    return 32'hD0D0_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] ch(input int i);
    return params_out[i*DW +: DW];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-22s obs=%08h exp=%08h ok", tag, obs, exp);
    end else begin
      $display("FAIL %-22s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [31:0] w);
    wire_hi = w[31:16];
    wire_lo = w[15:0];
  endtask

  initial begin
    reset       = 1'b0;
    trig        = '0;
    wire_lo     = '0;
    wire_hi     = '0;
    commit_tick = 1'b0;
    soft_clear  = 1'b0;
    rd_sel      = '0;
`ifdef TRIG_PARAM_BANK_SHADOW_RD_EN
    rd_shadow   = 1'b0;
`endif

    // 1. Reset state
    step(); step();
    check("rst_ch0",        ch(0),                      32'h42A0_0000);
    check("rst_ch3",        ch(3),                      def_of(3));
    check("rst_pending",    32'(pending),               32'h0);
    check("rst_overrun",    32'(overrun_cnt),           32'h0);
    check("rst_strobe",     32'(update_strobe),         32'h0);
    check("rst_rd_data",    rd_data,                    32'h0);
    reset = 1'b1;
    step();
    check("rd_ch0",         rd_data,                    32'h42A0_0000);

    // 2. Single load and commit
    set_word(32'h3F66_6666); trig = 12'h008;
    step(); trig = '0;
    check("t2_pending",     32'(pending),               32'h008);
    check("t2_ch3_hold",    ch(3),                      def_of(3));
    commit_tick = 1'b1; rd_sel = 4'd3;
    step(); commit_tick = 1'b0;
    check("t2_ch3_commit",  ch(3),                      32'h3F66_6666);
    check("t2_strobe",      32'(update_strobe),         32'h1);
    check("t2_pending_clr", 32'(pending),               32'h0);
    step();
    check("t2_strobe_end",  32'(update_strobe),         32'h0);
    check("t2_rd_ch3",      rd_data,                    32'h3F66_6666);

    // 3. Overwrite while pending -> overrun
    set_word(32'h0000_0001); trig = 12'h020;
    step();
    set_word(32'h0000_0002);
    step(); trig = '0;
    check("t3_overrun",     32'(overrun_cnt),           32'h1);
    check("t3_pending",     32'(pending),               32'h020);
    commit_tick = 1'b1;
    step(); commit_tick = 1'b0;
    check("t3_ch5",         ch(5),                      32'h0000_0002);
    check("t3_overrun_hold",32'(overrun_cnt),           32'h1);

    // 4. Trigger and commit in the same cycle
    set_word(32'h0000_00AA); trig = 12'h004;
    step();
    set_word(32'h0000_00BB); commit_tick = 1'b1;
    step(); trig = '0; commit_tick = 1'b0;
    check("t4_ch2_old",     ch(2),                      32'h0000_00AA);
    check("t4_pending",     32'(pending),               32'h004);
    check("t4_no_overrun",  32'(overrun_cnt),           32'h1);
    check("t4_strobe",      32'(update_strobe),         32'h1);
    commit_tick = 1'b1;
    step(); commit_tick = 1'b0;
    check("t4_ch2_new",     ch(2),                      32'h0000_00BB);
    check("t4_pending_clr", 32'(pending),               32'h0);

    // 5. Multi-trigger, then soft_clear on the commit cycle
    set_word(32'h1234_5678); trig = 12'h082;
    step(); trig = '0;
    check("t5_pending",     32'(pending),               32'h082);
    commit_tick = 1'b1; soft_clear = 1'b1; rd_sel = 4'd3;
    step(); commit_tick = 1'b0; soft_clear = 1'b0;
    check("t5_ch1",         ch(1),                      def_of(1));
    check("t5_ch7",         ch(7),                      def_of(7));
    check("t5_ch3",         ch(3),                      def_of(3));
    check("t5_ch2",         ch(2),                      def_of(2));
    check("t5_pending",     32'(pending),               32'h0);
    check("t5_strobe",      32'(update_strobe),         32'h0);
    check("t5_overrun",     32'(overrun_cnt),           32'h0);
    check("t5_rd_data",     rd_data,                    32'h0);
    step();
    check("t5_strobe_end",  32'(update_strobe),         32'h0);
    // Two channels overrunning in one cycle count once.
    trig = 12'h082;
    step(); step(); trig = '0;
    check("t5_multi_ovr",   32'(overrun_cnt),           32'h1);

    // 6. Reset while channels are pending
    reset = 1'b0;
    #1;
    check("t6_rst_pending", 32'(pending),               32'h0);
    check("t6_rst_ovr",     32'(overrun_cnt),           32'h0);
    reset = 1'b1;
    step();
    commit_tick = 1'b1;
    step(); commit_tick = 1'b0;
    check("t6_ch1",         ch(1),                      def_of(1));
    check("t6_ch7",         ch(7),                      def_of(7));
    check("t6_strobe",      32'(update_strobe),         32'h0);
    rd_sel = 4'd7;
    step();
    check("t6_rd_ch7",      rd_data,                    def_of(7));
    rd_sel = 4'(NCH);
    step();
    check("t6_rd_oob",      rd_data,                    32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
